// File: rtl/mbist_pkg.sv
// mbist_pkg: shared types and March C- element tables for the MBIST sequencer.
//   state_t   - sequencer FSM states
//   E0..E5    - March element indices
//   *_TAB     - per-element bit tables indexed by element number
package mbist_pkg;

    typedef enum logic [2:0] {IDLE, WRITE, READ, CMP, DONE} state_t;

    localparam logic [2:0] E0 = 3'd0;
    localparam logic [2:0] E1 = 3'd1;
    localparam logic [2:0] E2 = 3'd2;
    localparam logic [2:0] E3 = 3'd3;
    localparam logic [2:0] E4 = 3'd4;
    localparam logic [2:0] E5 = 3'd5;

    // Tables are 8 bits wide so any 3-bit element index stays in range.
    localparam logic [7:0] DOWN_TAB   = (8'd1 << E3) | (8'd1 << E4);
    localparam logic [7:0] RD_BG_TAB  = (8'd1 << E2) | (8'd1 << E4);
    localparam logic [7:0] WR_BG_TAB  = (8'd1 << E1) | (8'd1 << E3);
    localparam logic [7:0] HAS_RD_TAB = (8'd1 << E1) | (8'd1 << E2) | (8'd1 << E3) | (8'd1 << E4) | (8'd1 << E5);
    localparam logic [7:0] HAS_WR_TAB = (8'd1 << E0) | (8'd1 << E1) | (8'd1 << E2) | (8'd1 << E3) | (8'd1 << E4);

    function automatic logic elem_bit(input logic [7:0] tab, input logic [2:0] e);
        return tab[e];
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: up/down address counter for one March element.
//   load/load_down - start a new element at 0 (up) or N-1 (down)
//   step/down      - advance one address in the current element's direction
//   addr           - registered address, drives the SRAM directly
//   last           - current address is the final one of the element
module mbist_addr_gen #(
    parameter int ADDR = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            load_down,
    input  logic            step,
    input  logic            down,
    output logic [ADDR-1:0] addr,
    output logic            last
);

    assign last = down ? (addr == '0) : (addr == {ADDR{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            addr <= '0;
        else if (load)
            addr <= load_down ? {ADDR{1'b1}} : '0;
        else if (step)
            addr <= down ? addr - 1'b1 : addr + 1'b1;
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- MBIST sequencer for a single-port synchronous SRAM.
//   start                   - launches a test from IDLE/DONE
//   mem_*                   - registered SRAM address/strobes/write data, mem_rdata back
//   busy/done/fail          - status, done and fail sticky until next start
//   fail_addr/elem/data     - address, element and raw read data of first mismatch
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR   = 4,
    parameter int DATA   = 8,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DATA-1:0] mem_rdata,
    output logic [ADDR-1:0] mem_addr,
    output logic            mem_we,
    output logic            mem_re,
    output logic [DATA-1:0] mem_wdata,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [ADDR-1:0] fail_addr,
    output logic [2:0]      fail_elem,
    output logic [DATA-1:0] fail_data
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_t     state, state_n;
    logic [2:0] elem, elem_n;
    logic [1:0] cnt, cnt_n;
    logic       ld, ld_down, step, last, mis, cap, clr;

    mbist_addr_gen #(.ADDR(ADDR)) u_addr (
        .clk       (clk),
        .rst       (rst),
        .load      (ld),
        .load_down (ld_down),
        .step      (step),
        .down      (elem_bit(DOWN_TAB, elem)),
        .addr      (mem_addr),
        .last      (last)
    );

    assign mis = mem_rdata != {DATA{elem_bit(RD_BG_TAB, elem)}};

    always_comb begin
        state_n = state;
        elem_n  = elem;
        cnt_n   = cnt;
        ld      = 1'b0;
        ld_down = 1'b0;
        step    = 1'b0;
        cap     = 1'b0;
        clr     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    clr     = 1'b1;
                    elem_n  = E0;
                    ld      = 1'b1;
                    ld_down = elem_bit(DOWN_TAB, E0);
                    state_n = WRITE;
                end
            end
            WRITE: begin
                if (!last) begin
                    step    = 1'b1;
                    state_n = (elem == E0) ? WRITE : READ;
                end else begin
                    // E5 has no write, so elem never overflows past E5 here.
                    elem_n  = 3'(elem + 3'd1);
                    ld      = 1'b1;
                    ld_down = elem_bit(DOWN_TAB, elem_n);
                    state_n = elem_bit(HAS_RD_TAB, elem_n) ? READ : WRITE;
                end
            end
            READ: begin
                cnt_n   = '0;
                state_n = CMP;
            end
            CMP: begin
                if (cnt != LAT_LAST) begin
                    cnt_n = 2'(cnt + 2'd1);
                end else if (mis) begin
                    cap     = 1'b1;
                    state_n = DONE;
                end else if (elem_bit(HAS_WR_TAB, elem)) begin
                    state_n = WRITE;
                end else if (last) begin
                    state_n = DONE;
                end else begin
                    step    = 1'b1;
                    state_n = READ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            elem      <= E0;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_data <= '0;
        end else begin
            state     <= state_n;
            elem      <= elem_n;
            cnt       <= cnt_n;
            // Strobes and write data are decoded from the next state so they
            // line up with the state they belong to while staying flop outputs.
            mem_we    <= state_n == WRITE;
            mem_re    <= state_n == READ;
            mem_wdata <= (state_n == WRITE) ? {DATA{elem_bit(WR_BG_TAB, elem_n)}} : '0;
            busy      <= state_n inside {WRITE, READ, CMP};
            done      <= state_n == DONE;
            if (clr) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_elem <= '0;
                fail_data <= '0;
            end else if (cap) begin
                fail      <= 1'b1;
                fail_addr <= mem_addr;
                fail_elem <= elem;
                fail_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: directed bench for the March C- sequencer with RD_LAT=1 and RD_LAT=2 SRAM models.
module tb_mbist_march_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st1 = 1'b0, st2 = 1'b0;

    logic [3:0] a1, a2, fa1, fa2;
    logic       we1, re1, b1, d1, f1, we2, re2, b2, d2, f2;
    logic [7:0] wd1, rd1, fd1, wd2, rd2, fd2, p2;
    logic [2:0] fe1, fe2;

    logic [7:0] m1 [16];
    logic [7:0] m2 [16];

    logic [3:0] sa1_addr = '0, sa0_addr = '0;
    logic [7:0] sa1_mask = '0, sa0_mask = '0;

    int checks = 0, failures = 0;
    int nrd = 0, nstb = 0, ov1 = 0, ov2 = 0;
    logic [3:0] rlog [512];

    mbist_march_ctrl #(.ADDR(4), .DATA(8), .RD_LAT(1)) u1 (
        .clk(clk), .rst(rst), .start(st1), .mem_rdata(rd1), .mem_addr(a1),
        .mem_we(we1), .mem_re(re1), .mem_wdata(wd1), .busy(b1), .done(d1),
        .fail(f1), .fail_addr(fa1), .fail_elem(fe1), .fail_data(fd1)
    );

    mbist_march_ctrl #(.ADDR(4), .DATA(8), .RD_LAT(2)) u2 (
        .clk(clk), .rst(rst), .start(st2), .mem_rdata(rd2), .mem_addr(a2),
        .mem_we(we2), .mem_re(re2), .mem_wdata(wd2), .busy(b2), .done(d2),
        .fail(f2), .fail_addr(fa2), .fail_elem(fe2), .fail_data(fd2)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] faulty(input logic [7:0] v, input logic [3:0] a);
        logic [7:0] r;
        r = v;
        if (a == sa1_addr) r = r | sa1_mask;
        if (a == sa0_addr) r = r & ~sa0_mask;
        return r;
    endfunction

    always @(posedge clk) begin
        if (we1) m1[a1] <= wd1;
        rd1 <= faulty(m1[a1], a1);
    end

    always @(posedge clk) begin
        if (we2) m2[a2] <= wd2;
        p2  <= m2[a2];
        rd2 <= p2;
    end

    always @(negedge clk) begin
        if (re1 && nrd < 512) begin
            rlog[nrd] = a1;
            nrd++;
        end
        if (we1 || re1) nstb++;
        if (we1 && re1) ov1++;
        if (we2 && re2) ov2++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input bit sel, input int stop_at, output int edges);
        @(negedge clk);
        if (sel) st2 = 1'b1; else st1 = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        st1 = 1'b0;
        st2 = 1'b0;
        while (!(sel ? d2 : d1) && edges < 2000 && edges != stop_at) begin
            @(posedge clk);
            edges++;
            #1;
            if (sel && edges == 50) st2 = 1'b1;
            if (sel && edges == 60) st2 = 1'b0;
        end
    endtask

    initial begin
        int e, base, s;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_u1", {a1, we1, re1, wd1, b1, d1, f1, fa1, fe1, fd1}, 32'h0);
        chk("rst_u2", {a2, we2, re2, wd2, b2, d2, f2, fa2, fe2, fd2}, 32'h0);
        @(negedge clk) rst = 1'b0;

        base = nrd;
        run(1'b0, 0, e);
        chk("pass_edges", e, 241);
        chk("pass_done", d1, 1);
        chk("pass_fail", f1, 0);
        chk("pass_busy", b1, 0);
        chk("pass_overlap", ov1, 0);
        chk("pass_nreads", nrd - base, 80);
        chk("e1_first_addr", rlog[base], 0);
        chk("e3_first_addr", rlog[base + 32], 15);
        chk("e3_last_addr", rlog[base + 47], 0);
        chk("e4_first_addr", rlog[base + 48], 15);
        for (int i = 0; i < 16; i++) chk($sformatf("e5_addr%0d", i), rlog[base + 64 + i], i);

        run(1'b1, 0, e);
        chk("lat2_edges", e, 321);
        chk("lat2_done", d2, 1);
        chk("lat2_fail", f2, 0);
        chk("lat2_busy", b2, 0);
        chk("lat2_overlap", ov2, 0);

        sa1_addr = 4'd0;
        sa1_mask = 8'h01;
        run(1'b0, 0, e);
        chk("sa1_edges", e, 19);
        chk("sa1_done", d1, 1);
        chk("sa1_fail", f1, 1);
        chk("sa1_busy", b1, 0);
        chk("sa1_addr", fa1, 0);
        chk("sa1_elem", fe1, 1);
        chk("sa1_data", fd1, 8'h01);
        s = nstb;
        repeat (20) @(posedge clk);
        #1;
        chk("sa1_no_strobes", nstb - s, 0);
        chk("sa1_fail_sticky", {d1, f1}, 2'b11);

        sa1_mask = 8'h00;
        sa0_addr = 4'd5;
        sa0_mask = 8'h08;
        run(1'b0, 0, e);
        chk("sa0_edges", e, 82);
        chk("sa0_fail", f1, 1);
        chk("sa0_addr", fa1, 5);
        chk("sa0_elem", fe1, 2);
        chk("sa0_data", fd1, 8'hF7);
        sa0_mask = 8'h00;

        run(1'b0, 100, e);
        chk("mid_busy", b1, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_u1", {a1, we1, re1, wd1, b1, d1, f1, fa1, fe1, fd1}, 32'h0);
        @(negedge clk) rst = 1'b0;
        run(1'b0, 0, e);
        chk("rerun_edges", e, 241);
        chk("rerun_done_fail", {d1, f1, b1}, 3'b100);
        chk("final_overlap", ov1 + ov2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
Self-contained March C- MBIST sequencer for a single-port synchronous SRAM.
It generates address, read/write strobes and data background, compares read data internally, and reports pass/fail with fail address, element and data.
It replaces the simple two-pattern controller and sits between the SRAM test-mux and the top-level BIST status registers.

Parameters:
ADDR, 4, address width; memory depth N = 2**ADDR
DATA, 8, data width
RD_LAT, 1, SRAM read latency in cycles (legal range 1..4); mem_rdata is valid RD_LAT cycles after the mem_re cycle

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  level-sampled in IDLE/DONE; launches a test
mem_rdata  input  DATA  SRAM read data
mem_addr  output  ADDR  SRAM address, registered
mem_we  output  1  SRAM write strobe, registered
mem_re  output  1  SRAM read strobe, registered
mem_wdata  output  DATA  write data, registered: all-0 or all-1 background
busy  output  1  test in progress
done  output  1  sticky, test finished (pass or fail)
fail  output  1  sticky, mismatch detected
fail_addr  output  ADDR  address of first mismatch
fail_elem  output  3  March element index (0..5) of first mismatch
fail_data  output  DATA  raw mem_rdata captured at first mismatch

Behaviour:
- Reset: all outputs 0; state IDLE.
- March C- elements, executed in this order:
  - E0 up w0
  - E1 up r0,w1
  - E2 up r1,w0
  - E3 down r0,w1
  - E4 down r1,w0
  - E5 up r0
- Address order: up runs 0..N-1; down runs N-1..0. Wrap at the end of an element is never used; the counter reloads for the next element.
- FSM states: IDLE, WRITE, READ, CMP, DONE.
  - IDLE/DONE + start=1: clear done/fail/fail_*, set busy, load E0 at address 0, go to WRITE.
  - WRITE: mem_we=1 for one cycle, mem_wdata = element's write background. Then:
    - if more addresses remain: advance the address; next op is READ, or WRITE again for E0;
    - otherwise: go to the next element's first op.
  - READ: mem_re=1 for one cycle. Then CMP for RD_LAT cycles; compare on the last CMP cycle against the expected background.
    - match, element has a write: go to WRITE at the same address.
    - match, E5: advance the address, or go to DONE after the last address.
    - mismatch: capture fail_addr = current address, fail_elem, fail_data = mem_rdata; set fail=1, done=1, busy=0; go to DONE. Remaining elements are aborted.
- mem_we/mem_re are never both high. Both are 0 in IDLE, CMP and DONE.
- Cycle count from the start-sampling edge to done rising: 1 + N + 4N(2+RD_LAT) + N(1+RD_LAT). For ADDR=4, RD_LAT=1 this is 241 edges.
- start while busy: ignored.
- done/fail hold until the next accepted start or reset.
- Reset mid-test: immediate return to IDLE with all outputs 0. No partial status is retained.
- Compare is full-width equality; any single-bit difference fails.

Decomposition:
- Package mbist_pkg holds:
  - state enum;
  - element index constants E0..E5;
  - per-element tables: direction, read-expected background, write background, has_read, has_write.
- Sub-module mbist_addr_gen: ADDR-bit up/down counter with load-first, step, and last flag. Up direction loads 0 and asserts last at N-1; down direction loads N-1 and asserts last at 0.

Test Plan:
- Fault-free SRAM model, ADDR=4, DATA=8, RD_LAT=1, start pulse -> done=1 exactly 241 edges after the start edge, fail=0, busy low afterwards, mem_we/mem_re never overlap.
- Stuck-at-1 on bit 0 of address 0 -> fail at E1, fail_addr=0, fail_elem=1, fail_data=8'h01, done=1, no further strobes.
- Stuck-at-0 on bit 3 of address 5 -> fail at E2, fail_addr=5, fail_elem=2, fail_data=8'hF7.
- Address-order check, fault-free run -> E3 first read is at mem_addr=15 and last at 0; E5 runs 0..15.
- RD_LAT=2, fault-free run -> done after 1+16+256+48=321 edges; compare aligned to rdata; start reasserted mid-test is ignored.
- rst asserted at cycle 100 of a run -> all outputs 0 asynchronously. A following start runs a full 241-edge pass.
